// File: rtl/cy_tlb_walker.sv
// Hardware page-table walker for the cy TLB: walks a 4-level radix table over AXI
// and issues the TLB fill and resume soft-register writes, or latches a fault.
module cy_tlb_walker #(
  parameter int              ID_W    = 16,
  parameter logic [ID_W-1:0] WALK_ID = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     ptbr,
  input  logic            miss_valid,
  input  logic [63:0]     miss_vaddr,
  input  logic            miss_read,
  output logic            fill_valid,
  output logic [31:0]     fill_addr,
  output logic [63:0]     fill_data,
  output logic            arvalid,
  input  logic            arready,
  output logic [63:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  input  logic            rvalid,
  output logic            rready,
  input  logic [511:0]    rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  output logic            fault,
  output logic [63:0]     fault_vaddr,
  input  logic            fault_clear,
  output logic [31:0]     walk_count,
  output logic [31:0]     fault_count
);

  // AR/R handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; arvalid/araddr are held stable until arready is seen.
  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_RWAIT, S_DECODE, S_FILL, S_RESUME, S_DRAIN, S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] vaddr_q, vaddr_d;
  logic        read_q, read_d;
  logic [1:0]  level_q, level_d;
  logic [63:0] base_q, base_d;
  logic [63:0] pte_q, pte_d;
  logic        large_q, large_d;
  logic [1:0]  way2_q, way2_d;
  logic        way1_q, way1_d;
  logic [63:0] fault_vaddr_q, fault_vaddr_d;
  logic [31:0] walk_count_q, walk_count_d;
  logic [31:0] fault_count_q, fault_count_d;

  logic [8:0]  idx;
  logic [63:0] pte_addr;
  logic [8:0]  lane_lsb;
  logic        perm_ok;
  logic        go_fault;
  logic        unused_bits;

  always_comb begin
    idx = vaddr_q[20:12];
    case (level_q)
      2'd0:    idx = vaddr_q[47:39];
      2'd1:    idx = vaddr_q[38:30];
      2'd2:    idx = vaddr_q[29:21];
      default: idx = vaddr_q[20:12];
    endcase
  end

  assign pte_addr = base_q + {52'h0, idx, 3'b000};
  assign lane_lsb = {pte_addr[5:3], 6'b000000};
  assign perm_ok  = read_q ? pte_q[1] : pte_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vaddr_q       <= '0;
      read_q        <= 1'b0;
      level_q       <= '0;
      base_q        <= '0;
      pte_q         <= '0;
      large_q       <= 1'b0;
      way2_q        <= '0;
      way1_q        <= 1'b0;
      fault_vaddr_q <= '0;
      walk_count_q  <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      read_q        <= read_d;
      level_q       <= level_d;
      base_q        <= base_d;
      pte_q         <= pte_d;
      large_q       <= large_d;
      way2_q        <= way2_d;
      way1_q        <= way1_d;
      fault_vaddr_q <= fault_vaddr_d;
      walk_count_q  <= walk_count_d;
      fault_count_q <= fault_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vaddr_d       = vaddr_q;
    read_d        = read_q;
    level_d       = level_q;
    base_d        = base_q;
    pte_d         = pte_q;
    large_d       = large_q;
    way2_d        = way2_q;
    way1_d        = way1_q;
    fault_vaddr_d = fault_vaddr_q;
    walk_count_d  = walk_count_q;
    fault_count_d = fault_count_q;
    go_fault      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          vaddr_d = miss_vaddr;
          read_d  = miss_read;
          level_d = 2'd0;
          base_d  = {ptbr[63:12], 12'h000};
          if (|miss_vaddr[63:48]) go_fault = 1'b1;
          else                    state_d  = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (rvalid) begin
          pte_d = rdata[lane_lsb +: 64];
          if (rresp != 2'b00) go_fault = 1'b1;
          else                state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Only 4KB (L3) and 2MB (L2) leaves are representable in the TLB.
        if (!pte_q[0]) begin
          go_fault = 1'b1;
        end else if (!pte_q[7]) begin
          if (level_q == 2'd3) begin
            go_fault = 1'b1;
          end else begin
            base_d  = {28'h0, pte_q[35:12], 12'h000};
            level_d = level_q + 2'd1;
            state_d = S_AR;
          end
        end else if (level_q < 2'd2) begin
          go_fault = 1'b1;
        end else if (!perm_ok) begin
          go_fault = 1'b1;
        end else begin
          large_d = (level_q == 2'd2);
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (large_q) way1_d = ~way1_q;
        else         way2_d = way2_q + 2'd1;
        state_d = S_RESUME;
      end
      S_RESUME: begin
        walk_count_d = walk_count_q + 32'd1;
        state_d      = S_DRAIN;
      end
      S_DRAIN: begin
        if (!miss_valid) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear) state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_fault) begin
      state_d       = S_FAULT;
      fault_count_d = fault_count_q + 32'd1;
      fault_vaddr_d = (state_q == S_IDLE) ? miss_vaddr : vaddr_q;
    end
  end

  always_comb begin
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    if (state_q == S_FILL) begin
      fill_valid = 1'b1;
      if (large_q) begin
        fill_addr = {16'h0, 2'b01, vaddr_q[26:21], way1_q, 7'h00};
        fill_data = {vaddr_q[47:21], 9'h000, pte_q[35:21], 10'h000, pte_q[2:1], 1'b1};
      end else begin
        fill_addr = {16'h0, 1'b1, vaddr_q[21:12], way2_q, 3'b000};
        fill_data = {vaddr_q[47:12], pte_q[35:12], 1'b0, pte_q[2:1], 1'b1};
      end
    end else if (state_q == S_RESUME) begin
      fill_valid = 1'b1;
      fill_addr  = 32'h0000_0008;
    end
  end

  assign arvalid     = (state_q == S_AR);
  assign araddr      = arvalid ? {pte_addr[63:6], 6'b000000} : 64'h0;
  assign arid        = WALK_ID;
  assign arlen       = 8'h00;
  assign arsize      = 3'b110;
  // A beat left over from an aborted walk is swallowed while idle; rst_n gating
  // keeps rready low while reset is held.
  assign rready      = ((state_q == S_IDLE) && rst_n) || (state_q == S_RWAIT);
  assign fault       = (state_q == S_FAULT);
  assign fault_vaddr = fault_vaddr_q;
  assign walk_count  = walk_count_q;
  assign fault_count = fault_count_q;

  assign unused_bits = ^{rlast, ptbr[11:0], pte_q[63:36], pte_q[6:3], pte_addr[2:0]};

endmodule
